led_clock_monitor: RTL and testbench



---
 rtl/led_clock_monitor.sv | 138 +++++++++++++
 tb/tb_led_clock_monitor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/led_clock_monitor.sv
// Slow-clock link monitor: synchronises an external slow clock, measures each high/low
// phase in sys_clk cycles, checks each completed period against expected lengths, flags loss.
module led_clock_monitor #(
    parameter int unsigned CNT_W    = 28,
    parameter int unsigned EXP_HIGH = 100_000_000,
    parameter int unsigned EXP_LOW  = 50_000_000,
    parameter int unsigned TOL      = 1000,
    parameter int unsigned TIMEOUT  = 200_000_000
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             clk_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic             meas_valid,
    output logic             period_ok,
    output logic             clk_lost,
    output logic [7:0]       err_count
);

    typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW, LOST} state_t;

    localparam logic [CNT_W:0]   EXP_H_W   = (CNT_W+1)'(EXP_HIGH);
    localparam logic [CNT_W:0]   EXP_L_W   = (CNT_W+1)'(EXP_LOW);
    localparam logic [CNT_W:0]   TOL_W     = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(TIMEOUT);

    state_t           state, state_nxt;
    logic             sync1, sync2, sync_prev;
    logic             rise, fall, edge_seen, timeout_hit;
    logic [CNT_W-1:0] cnt, shadow_high;
    logic             cap_shadow, report, lost_set, lost_clr, ok_now;

    function automatic logic in_tol(input logic [CNT_W-1:0] meas, input logic [CNT_W:0] expv);
        logic [CNT_W:0] m;
        logic [CNT_W:0] d;
        m = {1'b0, meas};
        d = (m >= expv) ? (m - expv) : (expv - m);
        return (d <= TOL_W);
    endfunction

    // Chain presets to 1 so a high input at reset release does not look like a rise.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync1     <= clk_in;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    assign rise        = sync2 & ~sync_prev;
    assign fall        = ~sync2 & sync_prev;
    assign edge_seen   = rise | fall;
    assign timeout_hit = !edge_seen && (cnt == TIMEOUT_W);
    assign ok_now      = in_tol(shadow_high, EXP_H_W) && in_tol(cnt, EXP_L_W);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (edge_seen) begin
            cnt <= CNT_W'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cap_shadow = 1'b0;
        report     = 1'b0;
        lost_set   = 1'b0;
        lost_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise)             state_nxt = MEAS_HIGH;
                else if (timeout_hit) begin state_nxt = LOST; lost_set = 1'b1; end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    cap_shadow = 1'b1;
                    state_nxt  = MEAS_LOW;
                end else if (timeout_hit) begin
                    state_nxt = LOST;
                    lost_set  = 1'b1;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    report    = 1'b1;
                    state_nxt = MEAS_HIGH;
                end else if (timeout_hit) begin
                    state_nxt = LOST;
                    lost_set  = 1'b1;
                end
            end
            LOST: begin
                if (rise) begin
                    lost_clr  = 1'b1;
                    state_nxt = MEAS_HIGH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_high <= '0;
            high_time   <= '0;
            low_time    <= '0;
            meas_valid  <= 1'b0;
            period_ok   <= 1'b0;
            clk_lost    <= 1'b0;
            err_count   <= '0;
        end else begin
            meas_valid <= report;
            if (cap_shadow) shadow_high <= cnt;
            if (report) begin
                high_time <= shadow_high;
                low_time  <= cnt;
                period_ok <= ok_now;
                if (!ok_now && err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
            if (lost_set)      clk_lost <= 1'b1;
            else if (lost_clr) clk_lost <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_clock_monitor.sv
// Randomised bench for led_clock_monitor against an edge-timestamp reference model.
module tb_led_clock_monitor;

    localparam int CNT_W = 8, EXP_HIGH = 20, EXP_LOW = 10, TOL = 1, TIMEOUT = 64;

    logic             sys_clk = 1'b0;
    logic             rst_n;
    logic             clk_in;
    logic [CNT_W-1:0] high_time, low_time;
    logic             meas_valid, period_ok, clk_lost;
    logic [7:0]       err_count;

    int errors = 0;
    int checks = 0;

    led_clock_monitor #(
        .CNT_W(CNT_W), .EXP_HIGH(EXP_HIGH), .EXP_LOW(EXP_LOW), .TOL(TOL), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .clk_in(clk_in),
        .high_time(high_time), .low_time(low_time), .meas_valid(meas_valid),
        .period_ok(period_ok), .clk_lost(clk_lost), .err_count(err_count)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: mode 0 idle, 1 measuring high, 2 measuring low, 3 lost.
    int mode, n, last_edge, shadow;
    int m_high, m_low, m_err;
    bit m_valid, m_ok, m_lost;
    bit h1, h2, h3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit near(input int a, input int b);
        return ((a > b) ? a - b : b - a) <= TOL;
    endfunction

    task automatic model_reset();
        mode = 0; n = 0; last_edge = 1; shadow = 0;
        m_high = 0; m_low = 0; m_err = 0;
        m_valid = 0; m_ok = 0; m_lost = 0;
        h1 = 1; h2 = 1; h3 = 1;
    endtask

    // An input change is acted on at the third sys_clk edge that samples it.
    task automatic model_step(input bit v);
        bit r, f;
        int gap;
        n++;
        r = h2 & ~h3;
        f = ~h2 & h3;
        m_valid = 0;
        gap = n - last_edge;
        if (gap > 255) gap = 255;
        if (r || f) begin
            last_edge = n;
            case (mode)
                0: if (r) mode = 1;
                1: if (f) begin shadow = gap; mode = 2; end
                2: if (r) begin
                    m_high = shadow; m_low = gap; m_valid = 1;
                    m_ok = near(shadow, EXP_HIGH) && near(gap, EXP_LOW);
                    if (!m_ok && m_err < 255) m_err++;
                    mode = 1;
                end
                default: if (r) begin m_lost = 0; mode = 1; end
            endcase
        end else if (mode != 3 && gap == TIMEOUT) begin
            mode = 3;
            m_lost = 1;
        end
        h3 = h2; h2 = h1; h1 = v;
    endtask

    task automatic check_all();
        check("meas_valid", meas_valid, m_valid);
        check("clk_lost", clk_lost, m_lost);
        check("err_count", err_count, m_err);
        check("period_ok", period_ok, m_ok);
        check("high_time", high_time, m_high);
        check("low_time", low_time, m_low);
    endtask

    task automatic tick(input bit v);
        clk_in = v;
        @(posedge sys_clk);
        model_step(v);
        #1 check_all();
    endtask

    task automatic hold(input bit v, input int cycles);
        for (int i = 0; i < cycles; i++) tick(v);
    endtask

    task automatic period(input int hi, input int lo);
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    // Asserted between clock edges to exercise the asynchronous path.
    task automatic do_reset(input bit level);
        rst_n = 1'b0;
        clk_in = level;
        #1;
        check("rst high_time", high_time, 0);
        check("rst low_time", low_time, 0);
        check("rst meas_valid", meas_valid, 0);
        check("rst period_ok", period_ok, 0);
        check("rst clk_lost", clk_lost, 0);
        check("rst err_count", err_count, 0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b1;
        clk_in = 1'b0;
        model_reset();
        #2 do_reset(1'b0);

        hold(1'b0, 5);
        repeat (4) period(20, 10);

        period(22, 10);
        period(21, 9);
        period(19, 11);
        period(20, 12);
        period(20, 8);

        period(20, 10);
        hold(1'b1, 70);
        repeat (3) period(20, 10);
        period(64, 10);
        period(65, 10);
        period(20, 63);
        period(20, 64);
        period(20, 65);
        repeat (2) period(20, 10);

        for (int i = 0; i < 40; i++) begin
            int hi, lo;
            hi = $urandom_range(23, 17);
            lo = $urandom_range(13, 7);
            if ($urandom_range(9, 0) == 0) hi = $urandom_range(66, 62);
            if ($urandom_range(9, 0) == 0) lo = $urandom_range(66, 62);
            period(hi, lo);
        end

        do_reset(1'b1);
        hold(1'b1, 70);
        repeat (2) period(20, 10);

        period(20, 10);
        hold(1'b1, 20);
        hold(1'b0, 5);
        do_reset(1'b0);
        hold(1'b0, 3);
        repeat (3) period(20, 10);

        for (int i = 0; i < 300; i++) period(30, 10);
        period(20, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
